// File: rtl/lcd_sample_capture_controller_if.sv
// Sample input and DAC frame-buffer write bus for lcd_sample_capture_controller.
// The slave side is the capture controller; the master side feeds samples and receives writes.
interface lcd_sample_capture_controller_if #(
    parameter int DATA_WIDTH = 9
);
    logic                  SAMPLE_VALID;
    logic [DATA_WIDTH-1:0] SAMPLE_DATA;
    logic                  AUD_DAC_FRAME_START;
    logic                  AUD_DAC_DATA_WR;
    logic [DATA_WIDTH-1:0] AUD_DAC_DATA;
    logic                  AUD_DAC_FRAME_DONE;

    modport master (
        output SAMPLE_VALID,
        output SAMPLE_DATA,
        input  AUD_DAC_FRAME_START,
        input  AUD_DAC_DATA_WR,
        input  AUD_DAC_DATA,
        input  AUD_DAC_FRAME_DONE
    );

    modport slave (
        input  SAMPLE_VALID,
        input  SAMPLE_DATA,
        output AUD_DAC_FRAME_START,
        output AUD_DAC_DATA_WR,
        output AUD_DAC_DATA,
        output AUD_DAC_FRAME_DONE
    );
endinterface

// File: rtl/lcd_sample_capture_controller.sv
// Triggered oscilloscope-style sample capture into a frame buffer with decimation.
// Define AUTO_TRIGGER_EN to force a trigger after TIMEOUT_SAMPLES accepted samples in WAIT_TRIG.
module lcd_sample_capture_controller #(
    parameter int DATA_WIDTH      = 9,
    parameter int FRAME_LEN       = 480,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic                  AUD_CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] TRIG_LEVEL,
    input  logic                  TRIG_FALLING,
    input  logic [3:0]            DECIM,
    lcd_sample_capture_controller_if.slave bus,
    output logic                  ACTIVE_FRAME,
    output logic [7:0]            FRAME_COUNT,
    output logic                  AUTO_TRIGGERED,
    output logic                  BUSY
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TRIG = 2'd1;
    localparam logic [1:0] CAPTURE   = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam logic [9:0] FL = 10'(FRAME_LEN);

    if (FRAME_LEN < 2 || FRAME_LEN > 512 || TIMEOUT_SAMPLES < 1) begin : g_param_check
        $error("lcd_sample_capture_controller: parameter out of range");
    end

    logic [1:0]            state_q, state_d;
    logic [3:0]            dec_cnt_q;
    logic [9:0]            wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  fs_q;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  active_q, active_d;
    logic [7:0]            count_q, count_d;
    logic                  auto_q, auto_d;
    logic                  busy_q;

    logic running;
    logic accept;
    logic trig_hit;
    logic auto_hit;
    logic arm;

    assign running = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign accept  = running && bus.SAMPLE_VALID && (dec_cnt_q == DECIM);

    assign trig_hit = prev_valid_q &&
        (TRIG_FALLING ? ((prev_q > TRIG_LEVEL) && (bus.SAMPLE_DATA <= TRIG_LEVEL))
                      : ((prev_q < TRIG_LEVEL) && (bus.SAMPLE_DATA >= TRIG_LEVEL)));

`ifdef AUTO_TRIGGER_EN
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge AUD_CLK) begin
        if (RESET || arm) begin
            to_cnt_q <= '0;
        end else if ((state_q == WAIT_TRIG) && accept) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // the accepted sample that completes the timeout count is itself the forced write 0
    assign auto_hit = (to_cnt_q == TW'(TIMEOUT_SAMPLES - 1));
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_d         = 1'b0;
        data_d       = data_q;
        done_d       = 1'b0;
        active_d     = active_q;
        count_d      = count_q;
        auto_d       = auto_q;

        case (state_q)
            IDLE: begin
                if (ENABLE) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (trig_hit || auto_hit) begin
                        state_d  = CAPTURE;
                        wr_d     = 1'b1;
                        data_d   = bus.SAMPLE_DATA;
                        wr_cnt_d = 10'd1;
                        auto_d   = !trig_hit;
                    end
                    prev_d       = bus.SAMPLE_DATA;
                    prev_valid_d = 1'b1;
                end
            end
            CAPTURE: begin
                // the full count is seen in the cycle of the last write, so DONE follows it by one
                if (wr_cnt_q == FL) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (accept) begin
                    wr_d     = 1'b1;
                    data_d   = bus.SAMPLE_DATA;
                    wr_cnt_d = wr_cnt_q + 10'd1;
                end
            end
            DONE: begin
                active_d = ~active_q;
                count_d  = count_q + 8'd1;
                state_d  = ENABLE ? WAIT_TRIG : IDLE;
            end
            default: state_d = IDLE;
        endcase

        arm = (state_d == WAIT_TRIG) && (state_q != WAIT_TRIG);
        if (arm) begin
            prev_d       = '0;
            prev_valid_d = 1'b0;
            wr_cnt_d     = '0;
        end
    end

    always_ff @(posedge AUD_CLK) begin
        if (RESET || arm) begin
            dec_cnt_q <= '0;
        end else if (running && bus.SAMPLE_VALID) begin
            dec_cnt_q <= (dec_cnt_q == DECIM) ? 4'd0 : dec_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge AUD_CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            fs_q         <= 1'b0;
            wr_q         <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            active_q     <= 1'b0;
            count_q      <= '0;
            auto_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            fs_q         <= arm;
            wr_q         <= wr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            active_q     <= active_d;
            count_q      <= count_d;
            auto_q       <= auto_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.AUD_DAC_FRAME_START = fs_q;
    assign bus.AUD_DAC_DATA_WR     = wr_q;
    assign bus.AUD_DAC_DATA        = data_q;
    assign bus.AUD_DAC_FRAME_DONE  = done_q;
    assign ACTIVE_FRAME            = active_q;
    assign FRAME_COUNT             = count_q;
    assign AUTO_TRIGGERED          = auto_q;
    assign BUSY                    = busy_q;

endmodule

// File: tb/tb_lcd_sample_capture_controller.sv
// Scoreboard bench for lcd_sample_capture_controller: expected write data is queued as
// samples are driven and popped by a monitor on every DAC write strobe.
`timescale 1ns/1ps
module tb_lcd_sample_capture_controller;
    localparam int DW = 9;
    localparam int FL = 480;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          trig_falling = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [3:0]    decim = '0;
    logic          active_frame;
    logic [7:0]    frame_count;
    logic          auto_trig;
    logic          busy;

    lcd_sample_capture_controller_if #(.DATA_WIDTH(DW)) bus ();

    lcd_sample_capture_controller #(
        .DATA_WIDTH(DW),
        .FRAME_LEN(FL),
        .TIMEOUT_SAMPLES(TO)
    ) dut (
        .AUD_CLK(clk),
        .RESET(rst),
        .ENABLE(enable),
        .TRIG_LEVEL(trig_level),
        .TRIG_FALLING(trig_falling),
        .DECIM(decim),
        .bus(bus),
        .ACTIVE_FRAME(active_frame),
        .FRAME_COUNT(frame_count),
        .AUTO_TRIGGERED(auto_trig),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            gaps[$];
    int            cycle = 0;
    int            wr_total = 0;
    int            wr_frame = 0;
    int            done_total = 0;
    int            fs_total = 0;
    int            fs_at_done = 0;
    int            last_wr_cyc = -1000;

    always @(negedge clk) begin
        logic [DW-1:0] e;
        cycle++;
        if (bus.AUD_DAC_FRAME_START === 1'b1) begin
            fs_total++;
            checks++;
            if (bus.AUD_DAC_DATA_WR !== 1'b0) begin
                errors++;
                $display("FAIL wr_in_frame_start: wr=%b required 0", bus.AUD_DAC_DATA_WR);
            end
            wr_frame = 0;
        end
        if (bus.AUD_DAC_DATA_WR === 1'b1) begin
            if (wr_frame > 0) gaps.push_back(cycle - last_wr_cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_data: unexpected write data=%0d required no write", bus.AUD_DAC_DATA);
            end else begin
                e = exp_q.pop_front();
                if (bus.AUD_DAC_DATA !== e) begin
                    errors++;
                    $display("FAIL wr_data: got %0d required %0d", bus.AUD_DAC_DATA, e);
                end
            end
            wr_total++;
            wr_frame++;
            last_wr_cyc = cycle;
        end
        if (bus.AUD_DAC_FRAME_DONE === 1'b1) begin
            done_total++;
            fs_at_done = fs_total;
            checks++;
            if (last_wr_cyc != cycle - 1 || wr_frame != FL) begin
                errors++;
                $display("FAIL frame_done: cycles after last wr=%0d writes=%0d required 1 and %0d",
                         cycle - last_wr_cyc, wr_frame, FL);
            end
            wr_frame = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [DW-1:0] d);
        bus.SAMPLE_VALID = 1'b1;
        bus.SAMPLE_DATA  = d;
        @(posedge clk); #1;
        bus.SAMPLE_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        bus.SAMPLE_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        gaps.delete();
        wr_frame = 0;
        decim = '0;
        trig_falling = 1'b0;
        trig_level = DW'(256);
        @(posedge clk); #1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SAMPLE_VALID = 1'b0;
        bus.SAMPLE_DATA = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.AUD_DAC_FRAME_START, bus.AUD_DAC_DATA_WR, bus.AUD_DAC_FRAME_DONE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000",
                     {bus.AUD_DAC_FRAME_START, bus.AUD_DAC_DATA_WR, bus.AUD_DAC_FRAME_DONE});
        end
        checks++;
        if (bus.AUD_DAC_DATA !== '0) begin
            errors++;
            $display("FAIL reset_data: got %0d required 0", bus.AUD_DAC_DATA);
        end
        checks++;
        if (frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d required 0", frame_count);
        end
        checks++;
        if ({active_frame, auto_trig, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: active/auto/busy got %b required 000", {active_frame, auto_trig, busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rising();
        int fs_base, done_base, wr_base, n;
        do_reset();
        fs_base = fs_total;
        done_base = done_total;
        wr_base = wr_total;
        start_run();
        for (int v = 250; v < 256; v++) send(DW'(v));
        for (int k = 0; k < FL; k++) begin
            exp_q.push_back(DW'(256 + k));
            send(DW'(256 + k));
        end
        n = 0;
        while (done_total == done_base && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_total != done_base + 1) begin
            errors++;
            $display("FAIL rising_done: frame_done pulses=%0d required 1", done_total - done_base);
        end
        checks++;
        if (wr_total - wr_base != FL) begin
            errors++;
            $display("FAIL rising_wr_count: got %0d required %0d", wr_total - wr_base, FL);
        end
        checks++;
        if (fs_at_done - fs_base != 1) begin
            errors++;
            $display("FAIL rising_frame_start: got %0d required 1", fs_at_done - fs_base);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rising_pending: got %0d outstanding required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (active_frame !== 1'b1) begin
            errors++;
            $display("FAIL rising_active_frame: got %b required 1", active_frame);
        end
        checks++;
        if (frame_count !== 8'd1) begin
            errors++;
            $display("FAIL rising_frame_count: got %0d required 1", frame_count);
        end
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_falling();
        int wr_base;
        do_reset();
        trig_falling = 1'b1;
        start_run();
        wr_base = wr_total;
        send(DW'(256));
        send(DW'(256));
        checks++;
        if (wr_total != wr_base) begin
            errors++;
            $display("FAIL falling_equal_no_trig: writes=%0d required 0", wr_total - wr_base);
        end
        send(DW'(300));
        exp_q.push_back(DW'(200));
        send(DW'(200));
        checks++;
        if (wr_total != wr_base + 1) begin
            errors++;
            $display("FAIL falling_trig: writes=%0d required 1", wr_total - wr_base);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL falling_busy: got %b required 1", busy);
        end
    endtask

    task automatic test_enable_drop();
        int fs_base, done_base, wr_base;
        do_reset();
        start_run();
        fs_base = fs_total;
        done_base = done_total;
        wr_base = wr_total;
        send(DW'(100));
        for (int k = 0; k < FL; k++) begin
            exp_q.push_back(DW'(300 + k));
            send(DW'(300 + k));
            if (wr_total - wr_base == 10) enable = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_total != done_base + 1 || wr_total - wr_base != FL) begin
            errors++;
            $display("FAIL enable_drop_complete: done=%0d writes=%0d required 1 and %0d",
                     done_total - done_base, wr_total - wr_base, FL);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_busy: got %b required 0", busy);
        end
        checks++;
        if (frame_count !== 8'd1 || active_frame !== 1'b1) begin
            errors++;
            $display("FAIL enable_drop_frame: count=%0d active=%b required 1 and 1", frame_count, active_frame);
        end
        checks++;
        if (fs_total - fs_base != 0) begin
            errors++;
            $display("FAIL enable_drop_rearm: extra frame starts=%0d required 0", fs_total - fs_base);
        end
    endtask

    task automatic test_decim();
        int wr_base;
        logic [DW-1:0] d;
        do_reset();
        decim = 4'd3;
        start_run();
        wr_base = wr_total;
        for (int i = 0; i < 40; i++) begin
            d = (((i / 4) % 2) == 1) ? DW'(400) : DW'(100);
            if ((i % 4) == 3 && i >= 7) exp_q.push_back(d);
            send(d);
        end
        checks++;
        if (wr_total - wr_base != 9) begin
            errors++;
            $display("FAIL decim_wr_count: got %0d required 9", wr_total - wr_base);
        end
        checks++;
        if (gaps.size() != 8) begin
            errors++;
            $display("FAIL decim_gap_count: got %0d required 8", gaps.size());
        end
        foreach (gaps[j]) begin
            checks++;
            if (gaps[j] != 16) begin
                errors++;
                $display("FAIL decim_wr_spacing: gap %0d got %0d cycles required 16", j, gaps[j]);
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        int done_base, fs_base, wr_base;
        do_reset();
        start_run();
        done_base = done_total;
        wr_base = wr_total;
        send(DW'(100));
        for (int k = 0; k < 100; k++) begin
            exp_q.push_back(DW'(300 + k));
            send(DW'(300 + k));
        end
        checks++;
        if (wr_total - wr_base != 100) begin
            errors++;
            $display("FAIL midreset_pre_writes: got %0d required 100", wr_total - wr_base);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.AUD_DAC_FRAME_START, bus.AUD_DAC_DATA_WR, bus.AUD_DAC_FRAME_DONE, bus.AUD_DAC_DATA} !== '0) begin
            errors++;
            $display("FAIL midreset_dac: fs/wr/fd=%b data=%0d required all 0",
                     {bus.AUD_DAC_FRAME_START, bus.AUD_DAC_DATA_WR, bus.AUD_DAC_FRAME_DONE}, bus.AUD_DAC_DATA);
        end
        checks++;
        if ({active_frame, frame_count, auto_trig, busy} !== '0) begin
            errors++;
            $display("FAIL midreset_status: active=%b count=%0d auto=%b busy=%b required all 0",
                     active_frame, frame_count, auto_trig, busy);
        end
        rst = 1'b0;
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_total != done_base || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_no_done: done=%0d count=%0d required 0 and 0",
                     done_total - done_base, frame_count);
        end
        fs_base = fs_total;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fs_total != fs_base + 1) begin
            errors++;
            $display("FAIL midreset_fresh_start: frame starts=%0d required 1", fs_total - fs_base);
        end
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_auto_trigger();
        int wr_base;
        do_reset();
        start_run();
        wr_base = wr_total;
`ifdef AUTO_TRIGGER_EN
        for (int i = 0; i < TO - 1; i++) send(DW'(100));
        checks++;
        if (wr_total != wr_base) begin
            errors++;
            $display("FAIL auto_early: writes=%0d required 0", wr_total - wr_base);
        end
        exp_q.push_back(DW'(100));
        send(DW'(100));
        checks++;
        if (wr_total != wr_base + 1) begin
            errors++;
            $display("FAIL auto_write0: writes=%0d required 1", wr_total - wr_base);
        end
        checks++;
        if (auto_trig !== 1'b1) begin
            errors++;
            $display("FAIL auto_flag: got %b required 1", auto_trig);
        end
`else
        for (int i = 0; i < 40; i++) send(DW'(100));
        checks++;
        if (wr_total != wr_base) begin
            errors++;
            $display("FAIL auto_disabled_writes: got %0d required 0", wr_total - wr_base);
        end
        checks++;
        if (auto_trig !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_disabled_state: auto=%b busy=%b required 0 and 1", auto_trig, busy);
        end
`endif
        do_reset();
    endtask

    initial begin
        bus.SAMPLE_VALID = 1'b0;
        bus.SAMPLE_DATA  = '0;
        test_reset();
        test_falling();
        test_rising();
        test_enable_drop();
        test_decim();
        test_reset_mid_capture();
        test_auto_trigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
